// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: sequences an external round-key generator and stores round keys 0..NR.
module key_schedule_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [3:0]   rc,
  output logic [127:0] gen_inkey,
  input  logic [127:0] gen_outkey,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t       state_q, state_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] inkey_q, inkey_d;
  logic         busy_q, busy_d, done_q, done_d, kv_q, kv_d;
  logic [127:0] rk_q [0:NR];
  logic [127:0] rk_d [0:NR];
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    inkey_d = inkey_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    rk_d    = rk_q;
    if (state_q == IDLE) begin
      if (start) begin
        rk_d[0] = key_in;
        inkey_d = key_in;
        rc_d    = '0;
        kv_d    = 1'b0;
        busy_d  = 1'b1;
        state_d = EXPAND;
      end
    end else begin
      // rc names the round being produced minus one, so the result lands in rk[rc+1]
      for (int i = 1; i <= NR; i++) if (rc_q == 4'(i - 1)) rk_d[i] = gen_outkey;
      inkey_d = gen_outkey;
      rc_d    = rc_q + 4'd1;
      if (rc_q == 4'(NR - 1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        kv_d    = 1'b1;
        rc_d    = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= '0;
      inkey_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      inkey_q <= inkey_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
      rk_q    <= rk_d;
    end
  end
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++) if (rd_idx == 4'(i)) rd_key = rk_q[i];
  end
  assign rc         = rc_q;
  assign gen_inkey  = inkey_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = kv_q;
endmodule
